// File: rtl/rr_mux_reg.sv
// N-input registered selector with an internal round-robin or fixed-priority arbiter.
// One output stage with a valid/ready handshake; full throughput when the sink keeps up.
module rr_mux_reg #(
   parameter int WIDTH     = 32,
   parameter int N         = 4,
   parameter bit FIXED_PRI = 1'b0,
   localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [SEL_W-1:0] base;
   logic [SEL_W:0]   cand;
   logic             gnt_any;
   logic [SEL_W-1:0] gnt_idx;
   logic [N-1:0]     gnt_oh;
   logic             can_load;
   logic             accept;

   // Search starts at the pointer and wraps at N, not at 2**SEL_W.
   always_comb begin
      base    = FIXED_PRI ? '0 : ptr_q;
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, base} + (SEL_W+1)'(k);
         if (cand >= N_EXT) begin
            cand = cand - N_EXT;
         end
         if (!gnt_any && in_valid[cand[SEL_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      gnt_oh = '0;
      for (int j = 0; j < N; j++) begin
         gnt_oh[j] = gnt_any && (gnt_idx == SEL_W'(j));
      end
   end

   assign can_load = !out_valid_q || out_ready;
   assign accept   = gnt_any && can_load && !reset;
   assign in_ready = accept ? gnt_oh : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
         out_sel_d   = gnt_idx;
         ptr_d       = (gnt_idx == LAST) ? '0 : gnt_idx + SEL_W'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomised and directed bench for rr_mux_reg: three instances
// (N=4 round-robin, N=4 fixed priority, N=3 round-robin) against one model.
module tb_rr_mux_reg;

   logic         clk, reset;
   logic [3:0]   v4, vf;
   logic [2:0]   v3;
   logic [127:0] d4, df;
   logic [95:0]  d3;
   logic         r4, rf, r3;
   logic [3:0]   ir4, irf;
   logic [2:0]   ir3;
   logic         ov4, ovf, ov3;
   logic [31:0]  od4, odf, od3;
   logic [1:0]   os4, osf, os3;

   int vectors = 0;
   int miscompares = 0;

   rr_mux_reg #(.WIDTH(32), .N(4), .FIXED_PRI(1'b0)) u4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4),
      .in_ready(ir4), .out_valid(ov4), .out_data(od4),
      .out_sel(os4), .out_ready(r4));

   rr_mux_reg #(.WIDTH(32), .N(4), .FIXED_PRI(1'b1)) uf (
      .clk(clk), .reset(reset), .in_valid(vf), .in_data(df),
      .in_ready(irf), .out_valid(ovf), .out_data(odf),
      .out_sel(osf), .out_ready(rf));

   rr_mux_reg #(.WIDTH(32), .N(3), .FIXED_PRI(1'b0)) u3 (
      .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3),
      .in_ready(ir3), .out_valid(ov3), .out_data(od3),
      .out_sel(os3), .out_ready(r3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          mov  [3] = '{0, 0, 0};
   logic [31:0] mdat [3] = '{0, 0, 0};
   int          msel [3] = '{0, 0, 0};
   int          mptr [3] = '{0, 0, 0};

   function automatic int nof(int id);
      return (id == 2) ? 3 : 4;
   endfunction

   function automatic logic [3:0] gv(int id);
      case (id)
         0: return v4;
         1: return vf;
         default: return {1'b0, v3};
      endcase
   endfunction

   function automatic logic [31:0] gd(int id, int ch);
      case (id)
         0: return d4[ch*32 +: 32];
         1: return df[ch*32 +: 32];
         default: return d3[ch*32 +: 32];
      endcase
   endfunction

   function automatic bit gr(int id);
      case (id)
         0: return r4;
         1: return rf;
         default: return r3;
      endcase
   endfunction

   // First requesting channel in visiting order: ptr, ptr+1, ... mod n.
   function automatic int grant(int n, bit fx, int p, logic [3:0] v);
      for (int k = 0; k < n; k++) begin
         int i;
         i = fx ? k : (p + k) % n;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic int mgrant(int id);
      return grant(nof(id), id == 1, mptr[id], gv(id));
   endfunction

   function automatic bit maccept(int id);
      return mgrant(id) >= 0 && (!mov[id] || gr(id));
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int id = 0; id < 3; id++) begin
         if (reset) begin
            mov[id]  <= 1'b0;
            mdat[id] <= '0;
            msel[id] <= 0;
            mptr[id] <= 0;
         end else if (maccept(id)) begin
            mov[id]  <= 1'b1;
            mdat[id] <= gd(id, mgrant(id));
            msel[id] <= mgrant(id);
            mptr[id] <= (mgrant(id) + 1) % nof(id);
         end else if (gr(id)) begin
            mov[id] <= 1'b0;
         end
      end
   end

   // ---------------- compare process ----------------
   function automatic logic [3:0] exp_ir(int id);
      if (reset || !maccept(id)) return 4'b0000;
      return 4'b0001 << mgrant(id);
   endfunction

   function automatic logic [3:0] gir(int id);
      case (id)
         0: return ir4;
         1: return irf;
         default: return {1'b0, ir3};
      endcase
   endfunction

   function automatic logic gov(int id);
      case (id)
         0: return ov4;
         1: return ovf;
         default: return ov3;
      endcase
   endfunction

   function automatic logic [31:0] god(int id);
      case (id)
         0: return od4;
         1: return odf;
         default: return od3;
      endcase
   endfunction

   function automatic logic [1:0] gos(int id);
      case (id)
         0: return os4;
         1: return osf;
         default: return os3;
      endcase
   endfunction

   always @(negedge clk) begin
      for (int id = 0; id < 3; id++) begin
         chk($sformatf("in_ready[%0d]", id), gir(id), exp_ir(id));
         chk($sformatf("out_valid[%0d]", id), gov(id), mov[id]);
         chk($sformatf("out_data[%0d]", id), god(id), mdat[id]);
         chk($sformatf("out_sel[%0d]", id), gos(id), msel[id]);
      end
      chk("ptr_u4", u4.ptr_q, mptr[0]);
      chk("ptr_u3", u3.ptr_q, mptr[2]);
      chk("ptr_u3_lt_3", u3.ptr_q < 2'd3, 1);
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      r4 = 1'b0; rf = 1'b0; r3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d4[i*32 +: 32] = 32'hA000_0000 | i;
         df[i*32 +: 32] = 32'hA000_0000 | i;
      end
      for (int i = 0; i < 3; i++) d3[i*32 +: 32] = 32'hA000_0000 | i;
      v4 = 4'b1111; vf = 4'b1010; v3 = 3'b111;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", ov4, 0);
      chk("rst_out_data", od4, 0);
      chk("rst_out_sel", os4, 0);
      chk("rst_in_ready", ir4, 4'b0000);

      #1 reset = 1'b0; r4 = 1'b1; rf = 1'b1; r3 = 1'b1;
      #1 chk("first_grant", ir4, 4'b0001);

      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rr_data", od4, 32'hA000_0000 + 32'(c % 4));
         chk("rr_sel", os4, c % 4);
         chk("fixed_sel", osf, 1);
         chk("n3_sel", os3, c % 3);
      end

      @(negedge clk);
      chk("pre_hold_data", od4, 32'hA000_0001);
      #1 r4 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_in_ready", ir4, 4'b0000);
         chk("hold_data", od4, 32'hA000_0001);
      end
      #1 r4 = 1'b1;
      #1 chk("release_in_ready", ir4, 4'b0100);
      @(negedge clk);
      chk("release_data", od4, 32'hA000_0002);

      #1 v4 = 4'b0001;
      @(negedge clk);
      chk("skip_g0", os4, 0);
      #1 v4 = 4'b0100;
      @(negedge clk);
      chk("skip_g2", os4, 2);
      chk("skip_ptr3", u4.ptr_q, 3);
      #1 v4 = 4'b1011;
      @(negedge clk);
      chk("skip_g3", os4, 3);
      @(negedge clk);
      chk("skip_g0b", os4, 0);

      #1 r4 = 1'b0; v4 = 4'b1111;
      @(posedge clk);
      #1 chk("pre_rst_valid", ov4, 1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_valid", ov4, 0);
      chk("midrst_data", od4, 0);
      chk("midrst_sel", os4, 0);
      chk("midrst_in_ready", ir4, 4'b0000);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 chk("post_rst_grant", ir4, 4'b0001);
      @(negedge clk);
      chk("post_rst_sel", os4, 0);
      chk("post_rst_data", od4, 32'hA000_0000);

      repeat (3000) begin
         @(negedge clk);
         #1;
         v4 = 4'($urandom);
         vf = 4'($urandom);
         v3 = 3'($urandom);
         r4 = ($urandom_range(0, 9) < 7);
         rf = ($urandom_range(0, 9) < 7);
         r3 = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < 4; i++) begin
            d4[i*32 +: 32] = $urandom;
            df[i*32 +: 32] = $urandom;
         end
         for (int i = 0; i < 3; i++) d3[i*32 +: 32] = $urandom;
         reset = ($urandom_range(0, 299) == 0);
      end

      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
